// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-format and FSM state enums plus the baud divisor helper.
// Intended to be reused unchanged by the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // Rounds to the nearest whole number of sysclk cycles per bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data shows the head entry whenever not empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with transmit FIFO and a per-bit reloaded down-counter instead of a baud clock.
// Frames go out LSB first: start, DATA_BITS data, optional parity, STOP_BITS stop bits.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        finish,
  output logic                        UART_TX
);

  localparam int      CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int      CW       = $clog2(CPB);
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  if (CPB < 4) begin : g_bad_cpb
    $error("uart_tx_fifo_param: CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY < 0 || PARITY > 2) begin : g_bad_format
    $error("uart_tx_fifo_param: unsupported frame format");
  end

  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CPB - 1);

  tx_state_e            state;
  tx_state_e            state_next;
  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic                 bit_done;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sysclk  (sysclk),
    .reset   (reset),
    .wr_en   (tx_valid),
    .wr_data (tx_data[DATA_BITS-1:0]),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign busy     = (state != TX_IDLE);
  assign bit_done = (baud_cnt == '0);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          state_next = TX_START;
          pop        = 1'b1;
        end
      end
      TX_START:  if (bit_done) state_next = TX_DATA;
      TX_DATA: begin
        if (bit_done && bit_idx == 3'(DATA_BITS - 1))
          state_next = (PAR_MODE == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: if (bit_done) state_next = TX_STOP;
      TX_STOP: begin
        if (bit_done && bit_idx == 3'(STOP_BITS - 1)) state_next = TX_IDLE;
      end
      default:   state_next = TX_IDLE;
    endcase
  end

  // Every bit boundary reloads the counter, so each frame starts with a full bit period.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= TX_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        TX_IDLE: begin
          if (pop) begin
            baud_cnt   <= BAUD_RELOAD;
            bit_idx    <= '0;
            shift      <= fifo_head;
            parity_bit <= (PAR_MODE == PAR_ODD) ? ~^fifo_head : ^fifo_head;
          end
        end
        default: begin
          if (bit_done) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= (state_next != state) ? 3'd0 : bit_idx + 3'd1;
            if (state == TX_DATA) shift <= shift >> 1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Line and finish are registered, so they trail the FSM state by one cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      UART_TX <= 1'b1;
      finish  <= 1'b0;
    end else begin
      finish <= (state == TX_STOP) && (state_next == TX_IDLE);
      case (state)
        TX_START:  UART_TX <= 1'b0;
        TX_DATA:   UART_TX <= shift[0];
        TX_PARITY: UART_TX <= parity_bit;
        default:   UART_TX <= 1'b1;
      endcase
    end
  end

endmodule
